// File: rtl/pe_ingress_buffer.sv
// Elastic FWFT buffer between a PE output and a router local port.
// Packets addressed outside the mesh are consumed and counted, never stored.
module pe_ingress_buffer #(
    parameter int X                 = 2,
    parameter int Y                 = 2,
    parameter int data_width        = 256,
    parameter int pkt_no_field_size = 0,
    parameter int x_size            = $clog2(X),
    parameter int y_size            = $clog2(Y),
    parameter int total_width       = x_size + y_size + pkt_no_field_size + data_width,
    parameter int depth             = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    input  logic [total_width-1:0]     i_data,
    output logic                       o_ready,
    output logic                       o_valid,
    output logic [total_width-1:0]     o_data,
    input  logic                       i_ready,
    output logic [$clog2(depth):0]     occupancy,
    output logic [31:0]                fwd_count,
    output logic [31:0]                drop_count
);

    localparam int PTR_W = $clog2(depth);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [OCC_W-1:0] OCC_ONE  = {{(OCC_W-1){1'b0}}, 1'b1};
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(depth);
    localparam logic [31:0]      X_LIM    = 32'(X);
    localparam logic [31:0]      Y_LIM    = 32'(Y);

    logic [total_width-1:0] mem_r [depth];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [OCC_W-1:0]       occ_r;
    logic [31:0]            fwd_r;
    logic [31:0]            drop_r;
    logic                   x_ok_s;
    logic                   y_ok_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   store_s;
    logic                   discard_s;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // A zero-width coordinate field means that coordinate is always 0, hence legal.
    generate
        if (x_size > 0) begin : g_x_chk
            assign x_ok_s = ({{(32-x_size){1'b0}}, i_data[x_size-1:0]} < X_LIM);
        end else begin : g_x_none
            assign x_ok_s = 1'b1;
        end
        if (y_size > 0) begin : g_y_chk
            assign y_ok_s = ({{(32-y_size){1'b0}}, i_data[x_size+y_size-1:x_size]} < Y_LIM);
        end else begin : g_y_none
            assign y_ok_s = 1'b1;
        end
    endgenerate

    assign o_ready    = (occ_r != OCC_FULL);
    assign o_valid    = (occ_r != {OCC_W{1'b0}});
    assign o_data     = mem_r[rd_ptr_r];
    assign occupancy  = occ_r;
    assign fwd_count  = fwd_r;
    assign drop_count = drop_r;

    // Handshake decode; a handshake coinciding with reset is ignored.
    always_comb begin
        push_s    = i_valid && o_ready && !rst;
        pop_s     = o_valid && i_ready && !rst;
        store_s   = push_s && x_ok_s && y_ok_s;
        discard_s = push_s && !(x_ok_s && y_ok_s);
    end

    // Packet storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (store_s) begin
            mem_r[wr_ptr_r] <= i_data;
        end
    end

    // Pointers, occupancy and saturating statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= {OCC_W{1'b0}};
            fwd_r    <= 32'd0;
            drop_r   <= 32'd0;
        end else begin
            if (store_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
                fwd_r    <= sat_inc(fwd_r);
            end
            if (discard_s) begin
                drop_r <= sat_inc(drop_r);
            end
            case ({store_s, pop_s})
                2'b10:   occ_r <= occ_r + OCC_ONE;
                2'b01:   occ_r <= occ_r - OCC_ONE;
                default: occ_r <= occ_r;
            endcase
        end
    end

endmodule
